imem_uart_loader: RTL and testbench

//   Writer side of the instruction memory: receives a program image as a UART byte stream, assembles
//   big-endian 32-bit words and writes them into the instruction RAM at consecutive word addresses
//   (Address[ADDR_W+1:2]). Holds the pipeline CPU while loading. Sits between the UART RX byte

---
 rtl/imem_uart_loader.sv | 130 +++++++++++++
 tb/tb_imem_uart_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// Assembles a UART byte stream (HDR, N, 4*N payload, XOR checksum) into big-endian words and writes them to instruction RAM.
// Write strobe 1 clk after the 4th byte of each word; no back-pressure, one byte accepted per rx_valid.
module imem_uart_loader #(
  parameter int          ADDR_W  = 8,
  parameter int          TIMEOUT = 50000,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DATA, S_CSUM} state_t;

  state_t            state_q;
  logic [7:0]        n_q;
  logic [7:0]        wcnt_q;
  logic [7:0]        xor_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_sr_q;
  logic [TW-1:0]     idle_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              done_q;
  logic              err_q;

  logic [31:0] word_d;
  logic [7:0]  xor_d;

  assign word_d = {word_sr_q, rx_data};
  assign xor_d  = xor_q ^ rx_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      wcnt_q     <= '0;
      xor_q      <= '0;
      byte_idx_q <= '0;
      word_sr_q  <= '0;
      idle_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (wr_en_q) begin
        wr_addr_q <= wr_addr_q + 1'b1;
      end

      if (state_q == S_IDLE) begin
        if (rx_valid && load_en && rx_data == HDR) begin
          state_q   <= S_COUNT;
          err_q     <= 1'b0;
          wr_addr_q <= '0;
          xor_q     <= '0;
          idle_q    <= '0;
        end
      end else if (!load_en) begin
        err_q   <= 1'b1;
        state_q <= S_IDLE;
      end else if (rx_valid) begin
        // A byte landing on the timeout cycle is accepted, so it is tested first.
        idle_q <= '0;
        case (state_q)
          S_COUNT: begin
            n_q        <= rx_data;
            wcnt_q     <= '0;
            byte_idx_q <= '0;
            state_q    <= S_DATA;
          end
          S_DATA: begin
            word_sr_q  <= word_d[23:0];
            xor_q      <= xor_d;
            byte_idx_q <= byte_idx_q + 1'b1;
            if (byte_idx_q == 2'd3) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= word_d;
              // N==0 wraps n_q-1 to 255, giving a full 256-word frame.
              if (wcnt_q == n_q - 8'd1) begin
                state_q <= S_CSUM;
              end else begin
                wcnt_q <= wcnt_q + 8'd1;
              end
            end
          end
          S_CSUM: begin
            if (rx_data == xor_q) begin
              done_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (idle_q == IDLE_LAST) begin
        err_q   <= 1'b1;
        state_q <= S_IDLE;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != S_IDLE);
  assign cpu_hold = busy | err_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: frame loads, checksum errors, timeout, load_en abort, reset.
module tb_imem_uart_loader;
  localparam int ADDR_W = 8;
  localparam int TO     = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_en;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  imem_uart_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TO), .HDR(8'hA5)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write / done recorder sampled on the falling edge.
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];
  int                n_done = 0;
  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
    if (done) n_done++;
  end

  logic [7:0] tx_q[$];

  task automatic send_q();
    while (tx_q.size() > 0) begin
      @(negedge clk);
      rx_data  = tx_q.pop_front();
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
  endtask

  task automatic send1(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, dn;
    logic [7:0] cs;
    logic [7:0] v;
    logic [31:0] ew;

    reset = 1'b1; load_en = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctl",  {wr_en, cpu_hold, busy, done, err}, 5'b0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    reset = 1'b0;

    // 1: good two-word frame
    b = wa.size(); dn = n_done;
    tx_q = '{8'hA5, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0E};
    send_q();
    chk("t1_hold_mid", cpu_hold, 1);
    chk("t1_busy_mid", busy, 1);
    tx_q = '{8'h05};
    send_q();
    chk("t1_done", done, 1);
    chk("t1_hold_rel", cpu_hold, 0);
    chk("t1_nwr", wa.size() - b, 2);
    chk("t1_a0", wa[b], 0);
    chk("t1_d0", wd[b], 32'h08000003);
    chk("t1_a1", wa[b+1], 1);
    chk("t1_d1", wd[b+1], 32'h0000000E);
    @(negedge clk); #1;
    chk("t1_done_pulse", done, 0);

    // 2: bad checksum
    b = wa.size(); dn = n_done;
    tx_q = '{8'hA5, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0E, 8'h06};
    send_q();
    chk("t2_err", err, 1);
    chk("t2_hold", cpu_hold, 1);
    chk("t2_busy", busy, 0);
    chk("t2_nwr", wa.size() - b, 2);
    chk("t2_nodone", n_done - dn, 0);

    // 3: timeout after partial word
    b = wa.size();
    tx_q = '{8'hA5, 8'h01, 8'h12, 8'h34};
    send_q();
    chk("t3_err_clr", err, 0);
    repeat (TO - 1) @(negedge clk);
    #1;
    chk("t3_busy_pre", busy, 1);
    @(negedge clk); #1;
    chk("t3_busy_to", busy, 0);
    chk("t3_err_to", err, 1);
    chk("t3_nwr", wa.size() - b, 0);

    // 3b: byte arriving on the timeout cycle wins
    b = wa.size(); dn = n_done;
    tx_q = '{8'hA5, 8'h01};
    send_q();
    repeat (TO - 2) @(negedge clk);
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_q();
    chk("t3b_busy", busy, 1);
    tx_q = '{8'h04};
    send_q();
    chk("t3b_done", done, 1);
    chk("t3b_err", err, 0);
    chk("t3b_d0", wd[b], 32'h01020304);

    // 4: leading junk ignored, write latency
    b = wa.size();
    send1(8'h00);
    send1(8'hFF);
    chk("t4_junk_idle", busy, 0);
    send1(8'hA5);
    chk("t4_busy", busy, 1);
    send1(8'h01);
    send1(8'hDE);
    send1(8'hAD);
    send1(8'hBE);
    chk("t4_no_wr_early", wr_en, 0);
    send1(8'hEF);
    chk("t4_wr_en", wr_en, 1);
    chk("t4_wr_addr", wr_addr, 0);
    chk("t4_wr_data", wr_data, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("t4_wr_pulse", wr_en, 0);
    chk("t4_addr_inc", wr_addr, 1);
    send1(8'h22);
    chk("t4_done", done, 1);
    chk("t4_hold", cpu_hold, 0);

    // HDR value inside payload is data
    b = wa.size();
    tx_q = '{8'hA5, 8'h01, 8'hA5, 8'h00, 8'h00, 8'h01, 8'hA4};
    send_q();
    chk("hdr_data_done", done, 1);
    chk("hdr_data_wd", wd[b], 32'hA5000001);

    // 5: N=0 -> 256 words
    b = wa.size(); dn = n_done;
    cs = 8'h00;
    tx_q = '{8'hA5, 8'h00};
    for (int i = 0; i < 1024; i++) begin
      v = 8'(i);
      tx_q.push_back(v);
      cs ^= v;
    end
    tx_q.push_back(cs);
    send_q();
    chk("t5_done", done, 1);
    chk("t5_nwr", wa.size() - b, 256);
    for (int k = 0; k < 256; k++) begin
      ew = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      chk($sformatf("t5_a%0d", k), wa[b+k], k);
      chk($sformatf("t5_d%0d", k), wd[b+k], ew);
    end
    chk("t5_wrap", wr_addr, 0);

    // 6: load_en drop mid-frame, then reset mid-frame
    b = wa.size();
    tx_q = '{8'hA5, 8'h01, 8'h11, 8'h22};
    send_q();
    chk("t6_busy", busy, 1);
    @(negedge clk);
    load_en = 1'b0; rx_data = 8'h33; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; load_en = 1'b1;
    #1;
    chk("t6_err", err, 1);
    chk("t6_idle", busy, 0);
    chk("t6_hold", cpu_hold, 1);
    chk("t6_nwr", wa.size() - b, 0);
    tx_q = '{8'hA5, 8'h01, 8'h11};
    send_q();
    chk("t6_rst_pre", {busy, err}, 2'b10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("t6_rst_ctl",  {wr_en, cpu_hold, busy, done, err}, 5'b0);
    chk("t6_rst_addr", wr_addr, 0);
    chk("t6_rst_data", wr_data, 0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
